// File: rtl/maxnet_engine.sv
// maxnet_engine: iterative winner-take-all (MaxNet) stage.
// Repeatedly multiplies four unsigned activations by a 4x4 signed weight matrix
// (5-bit weights, FRAC fractional bits), clamps each row to [0, 2^DATA_W-1]
// and stops when at most one activation stays nonzero or after MAX_ITER passes.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-low reset
//   start               begin a competition (sampled only when idle)
//   x0..x3              initial activations
//   W0..W15             signed weights, W[4*j+i] feeds activation i into row j
//   a0..a3              current activation registers
//   busy                high while iterating
//   done                one-cycle completion pulse
//   winner              index of the sole nonzero activation
//   winner_valid        exactly one activation was nonzero at termination
//   timeout             run ended because MAX_ITER was reached
//   iter_cnt            iterations performed in the current/last run
module maxnet_engine #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned FRAC     = 3,
    parameter int unsigned MAX_ITER = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    input  logic [4:0]        W0,
    input  logic [4:0]        W1,
    input  logic [4:0]        W2,
    input  logic [4:0]        W3,
    input  logic [4:0]        W4,
    input  logic [4:0]        W5,
    input  logic [4:0]        W6,
    input  logic [4:0]        W7,
    input  logic [4:0]        W8,
    input  logic [4:0]        W9,
    input  logic [4:0]        W10,
    input  logic [4:0]        W11,
    input  logic [4:0]        W12,
    input  logic [4:0]        W13,
    input  logic [4:0]        W14,
    input  logic [4:0]        W15,
    output logic [DATA_W-1:0] a0,
    output logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] a2,
    output logic [DATA_W-1:0] a3,
    output logic              busy,
    output logic              done,
    output logic [1:0]        winner,
    output logic              winner_valid,
    output logic              timeout,
    output logic [3:0]        iter_cnt
);

    // Row sums need DATA_W+7 signed bits: 4 * (-16) * (2^DATA_W-1) still fits.
    localparam int unsigned SW = DATA_W + 7;
    localparam logic signed [SW-1:0] AMax = {{(SW-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q [4];
    logic [DATA_W-1:0] a_d [4];
    logic [3:0]        iter_q, iter_d;
    logic [1:0]        winner_q, winner_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;

    logic [DATA_W-1:0] x_arr [4];
    logic [4:0]        w_arr [16];
    logic signed [SW-1:0] sum_c [4];
    logic signed [SW-1:0] n_c   [4];
    logic [DATA_W-1:0] a_new [4];
    logic [2:0]        nz_cnt;
    logic [1:0]        nz_idx;
    logic              last_iter;

    assign x_arr = '{x0, x1, x2, x3};
    assign w_arr = '{W0, W1, W2, W3, W4, W5, W6, W7,
                     W8, W9, W10, W11, W12, W13, W14, W15};

    // Datapath: all four rows computed from the old activations in parallel.
    always_comb begin
        nz_cnt = '0;
        nz_idx = '0;
        for (int j = 0; j < 4; j++) begin
            sum_c[j] = '0;
            for (int i = 0; i < 4; i++) begin
                sum_c[j] = sum_c[j] +
                    $signed({{(SW-5){w_arr[4*j+i][4]}}, w_arr[4*j+i]}) *
                    $signed({{(SW-DATA_W){1'b0}}, a_q[i]});
            end
            n_c[j] = sum_c[j] >>> FRAC;
            if (n_c[j] < 0) begin
                a_new[j] = '0;
            end else if (n_c[j] > AMax) begin
                a_new[j] = '1;
            end else begin
                a_new[j] = n_c[j][DATA_W-1:0];
            end
            if (a_new[j] != '0) begin
                nz_cnt = nz_cnt + 3'd1;
                nz_idx = 2'(j);
            end
        end
    end

    assign last_iter = (32'(iter_q) + 32'd1) == MAX_ITER;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        iter_d    = iter_q;
        winner_d  = winner_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d       = x_arr;
                    iter_d    = '0;
                    winner_d  = '0;
                    valid_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = StIter;
                end
            end
            StIter: begin
                a_d    = a_new;
                iter_d = iter_q + 4'd1;
                // Convergence takes priority over the iteration limit.
                if (nz_cnt <= 3'd1) begin
                    state_d  = StDone;
                    valid_d  = (nz_cnt == 3'd1);
                    winner_d = (nz_cnt == 3'd1) ? nz_idx : 2'd0;
                end else if (last_iter) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                    valid_d   = 1'b0;
                    winner_d  = '0;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            a_q       <= '{default: '0};
            iter_q    <= '0;
            winner_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            iter_q    <= iter_d;
            winner_q  <= winner_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign a0           = a_q[0];
    assign a1           = a_q[1];
    assign a2           = a_q[2];
    assign a3           = a_q[3];
    assign busy         = (state_q == StIter);
    assign done         = (state_q == StDone);
    assign winner       = winner_q;
    assign winner_valid = valid_q;
    assign timeout      = timeout_q;
    assign iter_cnt     = iter_q;

endmodule
